// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: sequences lookups into the direct-mapped
// instruction cache and, on a miss, refills the word byte-serially over the
// shared memory port (little-endian) before returning it to the fetch unit.
module inst_fetch_ctrl #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rdy_in,
    input  logic                  flush,
    // fetch unit
    input  logic                  fetch_valid,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    output logic                  inst_valid,
    output logic [31:0]           inst_out,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    // instruction cache
    output logic [ADDR_WIDTH-1:0] cache_addr,
    input  logic                  cache_hit,
    input  logic [31:0]           cache_data,
    output logic                  upd_en,
    output logic [ADDR_WIDTH-1:0] upd_addr,
    output logic [31:0]           upd_data,
    // memory arbiter
    output logic                  mem_req,
    input  logic                  mem_gnt,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_din
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MISS  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [2:0]            issue_cnt_q, issue_cnt_d;
    logic [2:0]            recv_cnt_q, recv_cnt_d;
    logic                  inflight_q, inflight_d;
    logic [31:0]           word_q, word_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  inst_valid_q, inst_valid_d;
    logic [31:0]           inst_out_q, inst_out_d;
    logic [ADDR_WIDTH-1:0] inst_pc_q, inst_pc_d;
    logic                  upd_en_q, upd_en_d;
    logic [ADDR_WIDTH-1:0] upd_addr_q, upd_addr_d;
    logic [31:0]           upd_data_q, upd_data_d;

    logic accept;
    logic issue_fire;
    logic capture;
    logic last_capture;

    // The cache is looked up with the raw fetch PC; a request is only taken
    // while idle and not being redirected.
    assign cache_addr   = fetch_addr;
    assign fetch_ready  = (state_q == IDLE) && !flush;
    assign accept       = fetch_valid && fetch_ready && rdy_in;
    // A granted cycle puts one byte in flight; it returns the following cycle.
    assign issue_fire   = (state_q == MISS) && mem_req_q && mem_gnt;
    assign capture      = (state_q == MISS) && inflight_q;
    assign last_capture = capture && (recv_cnt_q == 3'd3);

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign inst_valid = inst_valid_q;
    assign inst_out   = inst_out_q;
    assign inst_pc    = inst_pc_q;
    assign upd_en     = upd_en_q;
    assign upd_addr   = upd_addr_q;
    assign upd_data   = upd_data_q;

    // State register; rdy_in low freezes the controller.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q <= IDLE;
        end else if (rdy_in) begin
            state_q <= state_d;
        end
    end

    // Next-state logic: flush wins over everything except the final byte,
    // and a byte already in flight must be drained before going idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept && !cache_hit) state_d = MISS;
            end
            MISS: begin
                if (last_capture)    state_d = IDLE;
                else if (flush)      state_d = issue_fire ? DRAIN : IDLE;
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values: hit return, byte issue/assembly,
    // and the refill/return pulses.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        base_d       = base_q;
        issue_cnt_d  = issue_cnt_q;
        recv_cnt_d   = recv_cnt_q;
        inflight_d   = 1'b0;
        word_d       = word_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        inst_valid_d = 1'b0;
        inst_out_d   = inst_out_q;
        inst_pc_d    = inst_pc_q;
        upd_en_d     = 1'b0;
        upd_addr_d   = upd_addr_q;
        upd_data_d   = upd_data_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cache_hit) begin
                        inst_valid_d = 1'b1;
                        inst_out_d   = cache_data;
                        inst_pc_d    = fetch_addr;
                    end else begin
                        base_d      = {fetch_addr[ADDR_WIDTH-1:2], 2'b00};
                        issue_cnt_d = 3'd0;
                        recv_cnt_d  = 3'd0;
                        word_d      = 32'd0;
                        mem_req_d   = 1'b1;
                        mem_addr_d  = {fetch_addr[ADDR_WIDTH-1:2], 2'b00};
                    end
                end
            end
            MISS: begin
                if (issue_fire) begin
                    issue_cnt_d = issue_cnt_q + 3'd1;
                    inflight_d  = 1'b1;
                    // After the fourth issue the address stays on base + 3.
                    if (issue_cnt_q == 3'd3) begin
                        mem_req_d = 1'b0;
                    end else begin
                        mem_addr_d = mem_addr_q + ADDR_WIDTH'(1);
                    end
                end
                if (capture) begin
                    word_d[{recv_cnt_q[1:0], 3'b000} +: 8] = mem_din;
                    recv_cnt_d = recv_cnt_q + 3'd1;
                    if (recv_cnt_q == 3'd3) begin
                        // The refilled word is valid even under flush, so the
                        // cache is still updated; only the return is dropped.
                        upd_en_d   = 1'b1;
                        upd_addr_d = base_q;
                        upd_data_d = word_d;
                        if (!flush) begin
                            inst_valid_d = 1'b1;
                            inst_out_d   = word_d;
                            inst_pc_d    = base_q;
                        end
                    end
                end
                if (flush && !last_capture) begin
                    mem_req_d  = 1'b0;
                    inflight_d = 1'b0;
                end
            end
            DRAIN: begin
                // The byte returning now belongs to an aborted miss; ignore it.
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; pulses and counters hold while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            base_q       <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            inflight_q   <= 1'b0;
            word_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            inst_valid_q <= 1'b0;
            inst_out_q   <= '0;
            inst_pc_q    <= '0;
            upd_en_q     <= 1'b0;
            upd_addr_q   <= '0;
            upd_data_q   <= '0;
        end else if (rdy_in) begin
            base_q       <= base_d;
            issue_cnt_q  <= issue_cnt_d;
            recv_cnt_q   <= recv_cnt_d;
            inflight_q   <= inflight_d;
            word_q       <= word_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_out_q   <= inst_out_d;
            inst_pc_q    <= inst_pc_d;
            upd_en_q     <= upd_en_d;
            upd_addr_q   <= upd_addr_d;
            upd_data_q   <= upd_data_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Scoreboard bench for inst_fetch_ctrl: a stimulus thread pushes expected
// returns/refills into queues, a monitor pops them when the DUT pulses, and a
// byte-wide memory plus arbiter model services misses.
module tb_inst_fetch_ctrl;

    localparam int AW = 32;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          rdy_in = 1'b1;
    logic          flush = 1'b0;
    logic          fetch_valid = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_ready;
    logic          inst_valid;
    logic [31:0]   inst_out;
    logic [AW-1:0] inst_pc;
    logic [AW-1:0] cache_addr;
    logic          cache_hit = 1'b0;
    logic [31:0]   cache_data = '0;
    logic          upd_en;
    logic [AW-1:0] upd_addr;
    logic [31:0]   upd_data;
    logic          mem_req;
    logic          mem_gnt = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din = '0;

    inst_fetch_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rdy_in      (rdy_in),
        .flush       (flush),
        .fetch_valid (fetch_valid),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .inst_valid  (inst_valid),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .cache_addr  (cache_addr),
        .cache_hit   (cache_hit),
        .cache_data  (cache_data),
        .upd_en      (upd_en),
        .upd_addr    (upd_addr),
        .upd_data    (upd_data),
        .mem_req     (mem_req),
        .mem_gnt     (mem_gnt),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din)
    );

    initial forever #5 clk_in = ~clk_in;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;   // expected visible cycle, -1 = not timed
    } exp_t;

    exp_t        inst_q[$];
    exp_t        upd_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          edge_rdy = 1'b1;
    int          gnt_mode = 0;      // 0 always, 1 random, 2 pattern queue
    bit          gnt_pat[$];
    logic [31:0] exp_maddr = '0;
    logic [7:0]  mem_arr [1024];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Reference word: four little-endian bytes from the memory model.
    function automatic logic [31:0] mem_word(input logic [31:0] base);
        logic [9:0] b;
        b = base[9:0];
        return {mem_arr[b + 10'd3], mem_arr[b + 10'd2], mem_arr[b + 10'd1], mem_arr[b]};
    endfunction

    // Cycle counter and the rdy_in value seen by the last edge.
    initial forever begin
        @(posedge clk_in);
        cyc++;
        edge_rdy = rdy_in;
    end

    // Memory: samples mem_addr on granted edges, returns the byte next cycle,
    // and checks the address sequence is base, base+1, ... in order.
    initial begin
        logic [7:0] nxt;
        nxt = '0;
        forever begin
            @(posedge clk_in);
            if (rst_n_in && rdy_in) begin
                if (mem_gnt) begin
                    check("mem_addr", 64'(mem_addr), 64'(exp_maddr));
                    exp_maddr = exp_maddr + 32'd1;
                    nxt = mem_arr[mem_addr[9:0]];
                end else begin
                    nxt = 8'($urandom);
                end
            end
            #1 mem_din = nxt;
        end
    end

    // Arbiter: decides the grant mid-cycle from the registered request.
    initial forever begin
        @(negedge clk_in);
        if (!rst_n_in) begin
            mem_gnt = 1'b0;
        end else if (rdy_in) begin
            if (!mem_req) begin
                mem_gnt = 1'b0;
            end else begin
                case (gnt_mode)
                    0:       mem_gnt = 1'b1;
                    1:       mem_gnt = ($urandom_range(0, 2) != 0);
                    default: mem_gnt = (gnt_pat.size() > 0) ? gnt_pat.pop_front() : 1'b1;
                endcase
            end
        end
    end

    // Monitor: every fresh pulse must match the head of its queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_in);
            if (rst_n_in && edge_rdy) begin
                if (inst_valid) begin
                    check("inst_expected", 64'(inst_q.size() > 0), 64'(1));
                    if (inst_q.size() > 0) begin
                        e = inst_q.pop_front();
                        check("inst_pc", 64'(inst_pc), 64'(e.addr));
                        check("inst_out", 64'(inst_out), 64'(e.data));
                        if (e.cyc >= 0) check("inst_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
                if (upd_en) begin
                    check("upd_expected", 64'(upd_q.size() > 0), 64'(1));
                    if (upd_q.size() > 0) begin
                        e = upd_q.pop_front();
                        check("upd_addr", 64'(upd_addr), 64'(e.addr));
                        check("upd_data", 64'(upd_data), 64'(e.data));
                        if (e.cyc >= 0) check("upd_cycle", 64'(cyc), 64'(e.cyc));
                    end
                end
            end
        end
    end

    // Issue one accepted fetch and queue what the DUT must produce for it.
    task automatic do_fetch(input logic [31:0] addr, input bit hit, input logic [31:0] cdata,
                            input int lat, input bit want_inst, input bit want_upd);
        exp_t e;
        e.cyc = (lat >= 0) ? cyc + lat : -1;
        if (hit) begin
            e.addr = addr;
            e.data = cdata;
            inst_q.push_back(e);
        end else begin
            e.addr = {addr[31:2], 2'b00};
            e.data = mem_word(e.addr);
            if (want_inst) inst_q.push_back(e);
            if (want_upd)  upd_q.push_back(e);
            exp_maddr = e.addr;
        end
        fetch_valid = 1'b1;
        fetch_addr  = addr;
        cache_hit   = hit;
        cache_data  = cdata;
        #1 check("cache_addr", 64'(cache_addr), 64'(addr));
        step();
        fetch_valid = 1'b0;
        cache_hit   = 1'b0;
        cache_data  = $urandom;
    endtask

    task automatic wait_ready(input bit random_rdy);
        int n;
        n = 0;
        while (!fetch_ready && n < 300) begin
            if (random_rdy) rdy_in = ($urandom_range(0, 3) != 0);
            step();
            n++;
        end
        rdy_in = 1'b1;
        check("ready_timeout", 64'(fetch_ready), 64'(1));
    endtask

    initial begin
        int n;
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 1024; i++) mem_arr[i] = 8'($urandom);
        mem_arr[10'h204] = 8'h13;
        mem_arr[10'h205] = 8'h05;
        mem_arr[10'h206] = 8'h10;
        mem_arr[10'h207] = 8'h00;

        // Reset values
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_inst_valid", 64'(inst_valid), 64'(0));
        check("rst_upd_en", 64'(upd_en), 64'(0));
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_inst_out", 64'(inst_out), 64'(0));
        check("rst_inst_pc", 64'(inst_pc), 64'(0));
        check("rst_upd_addr", 64'(upd_addr), 64'(0));
        check("rst_upd_data", 64'(upd_data), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_fetch_ready", 64'(fetch_ready), 64'(1));
        rst_n_in = 1'b1;
        step();

        // Hit, then back-to-back hits
        do_fetch(32'h100, 1'b1, 32'h00A00093, 1, 1'b1, 1'b0);
        check("hit_no_mem_req", 64'(mem_req), 64'(0));
        do_fetch(32'h104, 1'b1, $urandom, 1, 1'b1, 1'b0);
        do_fetch(32'h108, 1'b1, $urandom, 1, 1'b1, 1'b0);
        step();

        // Miss, continuous grant: 6-cycle latency
        gnt_mode = 0;
        do_fetch(32'h204, 1'b0, 32'h0, 6, 1'b1, 1'b1);
        wait_ready(1'b0);
        step();

        // Miss with grant gaps 1,0,0,1,1,0,1: last grant in cycle 7, return in 9
        gnt_mode = 2;
        gnt_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_fetch(32'h204, 1'b0, 32'h0, 9, 1'b1, 1'b1);
        wait_ready(1'b0);
        gnt_mode = 0;
        step();

        // Flush with byte 1 in flight: one DRAIN cycle, nothing produced
        do_fetch(32'h300, 1'b0, 32'h0, -1, 1'b0, 1'b0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("drain_not_ready", 64'(fetch_ready), 64'(0));
        check("drain_mem_req", 64'(mem_req), 64'(0));
        step();
        check("after_drain_ready", 64'(fetch_ready), 64'(1));
        do_fetch(32'h10C, 1'b1, $urandom, 1, 1'b1, 1'b0);
        step();

        // Flush on the byte-3 capture cycle: refill only
        do_fetch(32'h300, 1'b0, 32'h0, 6, 1'b0, 1'b1);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("flush_last_no_inst", 64'(inst_valid), 64'(0));
        check("flush_last_ready", 64'(fetch_ready), 64'(1));
        step();

        // rdy_in low for 3 cycles mid-miss delays completion by 3
        do_fetch(32'h204, 1'b0, 32'h0, 9, 1'b1, 1'b1);
        step();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_mem_addr", 64'(mem_addr), 64'(32'h205));
            check("stall_mem_req", 64'(mem_req), 64'(1));
        end
        rdy_in = 1'b1;
        wait_ready(1'b0);
        step();

        // Pulse held while stalled
        do_fetch(32'h110, 1'b1, $urandom, 1, 1'b1, 1'b0);
        rdy_in = 1'b0;
        step();
        check("hold_pulse_1", 64'(inst_valid), 64'(1));
        step();
        check("hold_pulse_2", 64'(inst_valid), 64'(1));
        rdy_in = 1'b1;
        step();
        check("pulse_cleared", 64'(inst_valid), 64'(0));

        // Flush in IDLE drops a hit presented in the same cycle
        fetch_valid = 1'b1;
        fetch_addr  = 32'h114;
        cache_hit   = 1'b1;
        cache_data  = $urandom;
        flush       = 1'b1;
        #1 check("flush_idle_not_ready", 64'(fetch_ready), 64'(0));
        step();
        fetch_valid = 1'b0;
        cache_hit   = 1'b0;
        flush       = 1'b0;
        #1 check("flush_idle_no_inst", 64'(inst_valid), 64'(0));
        step();

        // Asynchronous reset mid-miss
        do_fetch(32'h300, 1'b0, 32'h0, -1, 1'b0, 1'b0);
        step();
        #2 rst_n_in = 1'b0;
        #1;
        check("async_rst_mem_req", 64'(mem_req), 64'(0));
        check("async_rst_ready", 64'(fetch_ready), 64'(1));
        @(posedge clk_in);
        #1 rst_n_in = 1'b1;
        step();
        do_fetch(32'h118, 1'b1, $urandom, 1, 1'b1, 1'b0);

        // Randomized traffic with random grants and stalls
        for (int k = 0; k < 40; k++) begin
            wait_ready(1'b1);
            gnt_mode = $urandom_range(0, 1);
            do_fetch({22'd0, 8'($urandom), 2'b00}, 1'($urandom_range(0, 1)), $urandom,
                     -1, 1'b1, 1'b1);
        end

        // Drain outstanding expectations
        n = 0;
        while ((inst_q.size() > 0 || upd_q.size() > 0) && n < 300) begin
            rdy_in = 1'b1;
            step();
            n++;
        end
        step();
        check("inst_q_drained", 64'(inst_q.size()), 64'(0));
        check("upd_q_drained", 64'(upd_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
